// File: rtl/icache_refill.sv
// Set-associative instruction cache with a single-outstanding miss/refill controller.
// Victim choice is invalid-first, otherwise a per-set round-robin pointer.
module icache_refill #(
    parameter int BLOCK_BITS = 512,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 2,
    parameter int FETCH_BITS = 64,
    parameter int MEM_BITS   = 64,
    parameter int ADDR_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_BITS-1:0]  req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [FETCH_BITS-1:0] resp_data,
    output logic                  resp_miss,
    input  logic                  flush,
    output logic                  mem_req_valid,
    output logic [ADDR_BITS-1:0]  mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [MEM_BITS-1:0]   mem_resp_data
);
    localparam int OFF_BITS    = $clog2(BLOCK_BITS / 8);
    localparam int IDX_BITS    = $clog2(NUM_SETS);
    localparam int TAG_BITS    = ADDR_BITS - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int BEATS       = BLOCK_BITS / MEM_BITS;
    localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CHUNK_SHIFT = $clog2(FETCH_BITS / 8);

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_e;

    function automatic logic [FETCH_BITS-1:0] pick_chunk(input logic [BLOCK_BITS-1:0] line,
                                                         input logic [ADDR_BITS-1:0]  addr);
        logic [OFF_BITS-1:0] chunk;
        chunk = addr[OFF_BITS-1:0] >> CHUNK_SHIFT;
        return line[chunk*FETCH_BITS +: FETCH_BITS];
    endfunction

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [TAG_BITS-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
    logic [BLOCK_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]   rr_q    [NUM_SETS];

    state_e                state_q, state_d;
    logic [BEAT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [BLOCK_BITS-1:0] fill_q, fill_line;
    logic                  hit_vld_q;
    logic [FETCH_BITS-1:0] hit_data_q;

    logic                  hit, hit_fire, install, clear_all, beat_we, by_rr;
    logic [WAY_BITS-1:0]   hit_way, victim;
    logic [IDX_BITS-1:0]   req_idx, miss_idx;
    logic [TAG_BITS-1:0]   req_tag, miss_tag;

    assign req_idx  = req_addr[OFF_BITS +: IDX_BITS];
    assign req_tag  = req_addr[ADDR_BITS-1 -: TAG_BITS];
    assign miss_idx = addr_q[OFF_BITS +: IDX_BITS];
    assign miss_tag = addr_q[ADDR_BITS-1 -: TAG_BITS];

    // Descending scan so the lowest matching way wins if several ever match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        victim = (NUM_WAYS > 1) ? rr_q[miss_idx] : '0;
        by_rr  = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[miss_idx][w]) begin
                victim = WAY_BITS'(w);
                by_rr  = 1'b0;
            end
        end
    end

    // The last beat goes straight into the installed line, bypassing fill_q.
    always_comb begin
        fill_line = fill_q;
        fill_line[beat_cnt_q*MEM_BITS +: MEM_BITS] = mem_resp_data;
    end

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        flush_pend_d  = flush_pend_q;
        addr_d        = addr_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_miss     = 1'b0;
        hit_fire      = 1'b0;
        install       = 1'b0;
        clear_all     = 1'b0;
        beat_we       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
                if (flush) begin
                    clear_all = 1'b1;
                end else if (req_valid) begin
                    if (hit) begin
                        hit_fire = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (flush) flush_pend_d = 1'b1;
                if (mem_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_resp_valid) begin
                    beat_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_BITS'(BEATS - 1)) begin
                        install = !(flush_pend_q || flush);
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                resp_miss    = 1'b1;
                clear_all    = flush_pend_q || flush;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid   = hit_vld_q || (state_q == RESP);
    assign resp_data    = (state_q == RESP) ? pick_chunk(fill_q, addr_q) : hit_data_q;
    assign mem_req_addr = mem_req_valid ? {addr_q[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            hit_vld_q    <= 1'b0;
            hit_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            hit_vld_q    <= hit_fire;
            if (hit_fire) hit_data_q <= pick_chunk(data_q[req_idx][hit_way], req_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (clear_all) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else if (install) begin
            valid_q[miss_idx][victim] <= 1'b1;
            if (by_rr && (NUM_WAYS > 1)) rr_q[miss_idx] <= rr_q[miss_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        if (beat_we) fill_q <= fill_line;
        if (install) begin
            tag_q[miss_idx][victim]  <= miss_tag;
            data_q[miss_idx][victim] <= fill_line;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with default parameters: misses, hits, replacement,
// backpressure, flush and reset during refill.
module tb_icache_refill;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_miss;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    icache_refill dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_miss      (resp_miss),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_miss", resp_miss, 1'b0);
        chk("rst_resp_data", resp_data, 64'h0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, 32'h0);
        chk("rst_req_ready", req_ready, 1'b1);
    endtask

    task automatic hit(input logic [31:0] a, input logic [63:0] exp);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        chk("hit_valid", resp_valid, 1'b1);
        chk("hit_miss", resp_miss, 1'b0);
        chk("hit_data", resp_data, exp);
        chk("hit_no_mem_req", mem_req_valid, 1'b0);
    endtask

    // Full miss: request, optional request stall, 8 beats with optional gaps,
    // optional flush pulse alongside beat flush_beat, then the miss response.
    task automatic miss_fill(input logic [31:0] a, input logic [63:0] base,
                             input int stall, input int gap, input int flush_beat);
        logic [31:0] line;
        logic [63:0] exp;
        int          n;
        line = a & 32'hFFFF_FFC0;
        exp  = base + 64'((a >> 3) & 32'h7);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        chk("miss_req_ready_low", req_ready, 1'b0);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("mem_req_valid", mem_req_valid, 1'b1);
        chk("mem_req_addr", mem_req_addr, line);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_mem_req_valid", mem_req_valid, 1'b1);
            chk("stall_mem_req_addr", mem_req_addr, line);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("mem_req_drop", mem_req_valid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 64'(k);
            flush          = (k == flush_beat);
            tick();
            mem_resp_valid = 1'b0;
            flush          = 1'b0;
            if (k < 7) begin
                chk("no_early_resp", resp_valid, 1'b0);
                for (int g = 0; g < gap; g++) tick();
            end
        end
        chk("miss_resp_valid", resp_valid, 1'b1);
        chk("miss_resp_miss", resp_miss, 1'b1);
        chk("miss_resp_data", resp_data, exp);
        chk("miss_busy_in_resp", req_ready, 1'b0);
        tick();
        chk("miss_resp_pulse", resp_valid, 1'b0);
        chk("miss_ready_again", req_ready, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = 32'h0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'h0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs();

        // Cold miss then a hit in the freshly installed line
        miss_fill(32'h0000_1008, 64'hA000_0000_0000_0000, 0, 0, -1);
        hit(32'h0000_1010, 64'hA000_0000_0000_0002);

        // Replacement in set 0: invalid-first, then round-robin
        miss_fill(32'h0000_2000, 64'hB000_0000_0000_0000, 0, 0, -1);
        miss_fill(32'h0000_3000, 64'hC000_0000_0000_0000, 0, 0, -1);
        hit(32'h0000_2000, 64'hB000_0000_0000_0000);
        miss_fill(32'h0000_1000, 64'hA000_0000_0000_0000, 0, 0, -1);
        hit(32'h0000_3008, 64'hC000_0000_0000_0001);
        // 0x2000 was evicted; refetch it under request stall and beat gaps
        miss_fill(32'h0000_2000, 64'hD000_0000_0000_0000, 5, 3, -1);
        hit(32'h0000_2018, 64'hD000_0000_0000_0003);
        hit(32'h0000_1038, 64'hA000_0000_0000_0007);

        // Flush in IDLE blocks the simultaneous request and drops all lines
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_1000;
        #1;
        chk("flush_req_ready", req_ready, 1'b0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_no_resp", resp_valid, 1'b0);
        chk("flush_no_mem_req", mem_req_valid, 1'b0);
        miss_fill(32'h0000_1000, 64'hA000_0000_0000_0000, 0, 0, -1);

        // Flush during refill: response delivered, line not kept
        miss_fill(32'h0000_4040, 64'hE000_0000_0000_0000, 0, 0, 3);
        miss_fill(32'h0000_4048, 64'hE100_0000_0000_0000, 0, 0, -1);
        miss_fill(32'h0000_1000, 64'hA000_0000_0000_0000, 0, 0, -1);

        // Reset after 4 beats of a refill
        req_valid = 1'b1;
        req_addr  = 32'h0000_5000;
        tick();
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'hF000_0000_0000_0000 + 64'(k);
            tick();
        end
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs();
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'h9999_0000_0000_0000 + 64'(k);
            tick();
            chk("stray_no_resp", resp_valid, 1'b0);
            chk("stray_ready", req_ready, 1'b1);
        end
        mem_resp_valid = 1'b0;
        miss_fill(32'h0000_5000, 64'hF000_0000_0000_0000, 0, 0, -1);

        // Back-to-back hits
        miss_fill(32'h0000_1000, 64'hA000_0000_0000_0000, 0, 0, -1);
        req_valid = 1'b1;
        req_addr  = 32'h0000_1000;
        tick();
        chk("b2b_valid0", resp_valid, 1'b1);
        chk("b2b_data0", resp_data, 64'hA000_0000_0000_0000);
        req_addr = 32'h0000_1008;
        tick();
        chk("b2b_valid1", resp_valid, 1'b1);
        chk("b2b_data1", resp_data, 64'hA000_0000_0000_0001);
        req_addr = 32'h0000_1010;
        tick();
        chk("b2b_valid2", resp_valid, 1'b1);
        chk("b2b_data2", resp_data, 64'hA000_0000_0000_0002);
        chk("b2b_miss2", resp_miss, 1'b0);
        req_valid = 1'b0;
        tick();
        chk("b2b_end", resp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
